// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, LSB-first data, optional parity, 1/2 stop bits)
module uart_tx_frame #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUDRATE  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    output logic                 busy
);
    localparam int DIV = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
        $error("uart_tx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 par, par_n;
    logic                 tx_n, done_n;
    logic                 tick;

    assign tick     = cnt == CW'(DIV - 1);
    assign tx_ready = state == IDLE && !rst;
    assign busy     = state != IDLE;

    // state and line registers; reset parks the line high and drops any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            par     <= par_n;
            tx      <= tx_n;
            tx_done <= done_n;
        end
    end

    // next-state: each bit lasts DIV cycles; the next line level is registered at the bit boundary
    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        par_n   = par;
        tx_n    = tx;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (tx_valid && tx_ready) begin
                    state_n = START;
                    sh_n    = tx_data;
                    par_n   = ^tx_data ^ (PARITY == 1);
                    tx_n    = 1'b0;
                end
            end
            START: if (tick) begin
                state_n = DATA;
                idx_n   = '0;
                tx_n    = sh[0];
                sh_n    = sh >> 1;
            end
            DATA: if (tick) begin
                if (idx == 4'(DATA_BITS - 1)) begin
                    state_n = PARITY != 0 ? PAR : STOP;
                    tx_n    = PARITY != 0 ? par : 1'b1;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + 1'b1;
                    tx_n  = sh[0];
                    sh_n  = sh >> 1;
                end
            end
            PAR: if (tick) begin
                state_n = STOP;
                tx_n    = 1'b1;
                idx_n   = '0;
            end
            STOP: if (tick) begin
                if (idx == 4'(STOP_BITS - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
